shift_rows_pipe: RTL

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

---
 rtl/aes_pkg.sv | 21 ++
 rtl/shift_rows_perm.sv | 21 ++
 rtl/shift_rows_pipe.sv | 74 +++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state constants, row offsets and byte indexing
package aes_pkg;
    localparam int NB_128 = 4;
    localparam int NB_192 = 6;
    localparam int NB_256 = 8;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

    function automatic bit nb_legal(input int nb);
        return nb == NB_128 || nb == NB_192 || nb == NB_256;
    endfunction

    // Rijndael with 8 columns widens the lower two row offsets by one
    function automatic int shift_off(input int nb, input int r);
        return (nb == NB_256 && r >= 2) ? r + 1 : r;
    endfunction

    function automatic int byte_lsb(input int nb, input int c, input int r);
        return 32 * nb - 8 - 8 * (c * 4 + r);
    endfunction
endpackage

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: combinational ShiftRows / InvShiftRows over an NB-column state
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] din,
    input  logic             inv,
    output logic [32*NB-1:0] dout
);
    if (!nb_legal(NB)) begin : g_bad_nb
        $error("shift_rows_perm: NB must be 4, 6 or 8");
    end
    for (genvar r = 0; r < 4; r++) begin : g_r
        for (genvar c = 0; c < NB; c++) begin : g_c
            localparam int off = shift_off(NB, r);
            assign dout[byte_lsb(NB, c, r) +: 8] = inv ? din[byte_lsb(NB, (c - off + NB) % NB, r) +: 8]
                                                       : din[byte_lsb(NB, (c + off) % NB, r) +: 8];
        end
    end
endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: ShiftRows stage behind a 2-entry skid buffer with valid/ready on both sides
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    input  logic              in_inv,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag
);
    skid_state_t state, state_nxt;
    logic in_ready_q, in_xfer, out_xfer, head_ld, skid_ld;
    logic [32*NB-1:0] perm, head_data, skid_data;
    logic [TAG_W-1:0] head_tag, skid_tag;

    shift_rows_perm #(.NB(NB)) u_perm (.din(in_data), .inv(in_inv), .dout(perm));

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= state_nxt != FULL;
        end
    end

    always_comb begin
        state_nxt = (state == EMPTY) ? (in_xfer ? ONE : EMPTY)
                  : (state == ONE)   ? ((in_xfer && !out_xfer) ? FULL : (out_xfer && !in_xfer) ? EMPTY : ONE)
                  : (out_xfer ? ONE : FULL);
    end

    always_comb begin
        in_ready  = in_ready_q;
        out_valid = state != EMPTY;
        out_data  = head_data;
        out_tag   = head_tag;
    end

    // head is the presented beat; skid only fills when head is stalled
    assign head_ld = out_xfer ? (state == FULL || in_xfer) : (in_xfer && state == EMPTY);
    assign skid_ld = in_xfer && !out_xfer && state == ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_data <= '0;
            head_tag  <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else begin
            if (head_ld) begin
                head_data <= (state == FULL) ? skid_data : perm;
                head_tag  <= (state == FULL) ? skid_tag : in_tag;
            end
            if (skid_ld) begin
                skid_data <= perm;
                skid_tag  <= in_tag;
            end
        end
    end
endmodule
